distinct_history_tracker: RTL

Parametrised tracker of the most recent distinct values on a sampled data stream. It keeps DEPTH entries, with entry 0 as the newest and a per-entry valid flag. Two modes: CHANGE mode pushes a sample whenever it differs from the newest entry; MRU mode keeps entries unique and moves a repeated value to the front. It also provides per-sample hit reporting, freeze, synchronous clear and a saturating update counter. It sits beside the stream-monitor blocks as their generalised successor.

---
 rtl/dht_pkg.sv | 31 +++
 rtl/distinct_history_tracker_match.sv | 36 +++
 rtl/distinct_history_tracker.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dht_pkg.sv
// Shared types and width helpers for the distinct history tracker.
// Contents:
//   dht_mode_e  - history policy (adjacent-dedup shift or MRU move-to-front)
//   dht_state_e - control FSM states
//   idx_width() / cnt_width() - index and occupancy widths for a given depth
package dht_pkg;

  typedef enum logic {
    MODE_CHANGE = 1'b0,
    MODE_MRU    = 1'b1
  } dht_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } dht_state_e;

  localparam int DHT_MIN_DEPTH = 2;
  localparam int DHT_MAX_DEPTH = 16;

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy must represent DEPTH itself, hence one extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/distinct_history_tracker_match.sv
// hist_match_encoder: compares a sample against every valid history entry
// and reports the lowest matching index.
// Ports:
//   entries_in - flattened entries, entry i at [i*DATA_W +: DATA_W]
//   valid_in   - per-entry valid flags
//   data_in    - sample to compare
//   hit_out    - at least one valid entry equals data_in
//   idx_out    - lowest matching index, 0 when there is no hit
module hist_match_encoder
  import dht_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic [DEPTH*DATA_W-1:0]      entries_in,
  input  logic [DEPTH-1:0]             valid_in,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         hit_out,
  output logic [idx_width(DEPTH)-1:0]  idx_out
);

  localparam int IDX_W = idx_width(DEPTH);

  // Scanning from the top down lets the lowest match overwrite higher ones.
  always_comb begin
    hit_out = 1'b0;
    idx_out = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_in[i] && (entries_in[i*DATA_W +: DATA_W] == data_in)) begin
        hit_out = 1'b1;
        idx_out = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/distinct_history_tracker.sv
// distinct_history_tracker: keeps the DEPTH most recent distinct samples of
// a data stream, newest in entry 0.
//   MODE 0 (CHANGE): push whenever the sample differs from entry 0.
//   MODE 1 (MRU)   : entries are unique; a repeated value moves to the front.
// Ports:
//   clk_in, reset_in  - clock and asynchronous active-high reset
//   data_in, in_valid - sample and its qualifier
//   clear_in          - synchronous history clear (wins over freeze)
//   freeze_in         - hold the history; hit reporting continues
//   hist_data/valid   - flattened entries and thermometer valid flags
//   count_out         - number of valid entries
//   hit_out, hit_idx  - registered match report for each accepted sample
//   update_out        - pulse when entries or valid flags changed
//   upd_cnt_out       - saturating count of update pulses
module distinct_history_tracker
  import dht_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int MODE   = 0,
  parameter int CNT_W  = 16
) (
  input  logic                      clk_in,
  input  logic                      reset_in,
  input  logic [DATA_W-1:0]         data_in,
  input  logic                      in_valid,
  input  logic                      clear_in,
  input  logic                      freeze_in,
  output logic [DEPTH*DATA_W-1:0]   hist_data,
  output logic [DEPTH-1:0]          hist_valid,
  output logic [$clog2(DEPTH):0]    count_out,
  output logic                      hit_out,
  output logic [$clog2(DEPTH)-1:0]  hit_idx,
  output logic                      update_out,
  output logic [CNT_W-1:0]          upd_cnt_out
);

  localparam int IDX_W     = idx_width(DEPTH);
  localparam int CNT_OUT_W = cnt_width(DEPTH);
  localparam bit IS_MRU    = (MODE == int'(MODE_MRU));
  localparam logic [CNT_OUT_W-1:0] FULL    = CNT_OUT_W'(DEPTH);
  localparam logic [CNT_W-1:0]     UPD_MAX = '1;

  typedef logic [DEPTH-1:0][DATA_W-1:0] hist_t;

  dht_state_e             state_q, state_d;
  hist_t                  entries_q, entries_d;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [CNT_OUT_W-1:0]   count_q, count_d;
  logic                   hit_q, hit_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   upd_q, upd_d;
  logic [CNT_W-1:0]       upd_cnt_q, upd_cnt_d;

  logic                   match_hit;
  logic [IDX_W-1:0]       match_idx;
  logic                   active;
  logic                   accept;
  logic                   push;

  hist_match_encoder #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_match (
    .entries_in (entries_q),
    .valid_in   (valid_q),
    .data_in    (data_in),
    .hit_out    (match_hit),
    .idx_out    (match_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_RUN;
      ST_RUN:    if (freeze_in) state_d = ST_FROZEN;
      ST_FROZEN: if (!freeze_in) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active    = (state_q != ST_IDLE);
    accept    = active && in_valid;
    push      = 1'b0;
    entries_d = entries_q;
    valid_d   = valid_q;
    count_d   = count_q;
    hit_d     = 1'b0;
    idx_d     = '0;

    // A sample written by a clear starts a fresh history, so it never hits.
    if (accept && !clear_in) begin
      hit_d = match_hit;
      idx_d = match_idx;
    end

    if (active && clear_in) begin
      entries_d = '0;
      valid_d   = '0;
      count_d   = '0;
      if (accept) begin
        entries_d[0] = data_in;
        valid_d[0]   = 1'b1;
        count_d      = CNT_OUT_W'(1);
      end
    end else if (accept && !freeze_in) begin
      if (IS_MRU) push = !match_hit;
      else        push = (count_q == '0) || (data_in != entries_q[0]);

      if (push) begin
        entries_d = {entries_q[DEPTH-2:0], data_in};
        valid_d   = {valid_q[DEPTH-2:0], 1'b1};
        if (count_q != FULL) count_d = count_q + CNT_OUT_W'(1);
      end else if (IS_MRU && (match_idx != '0)) begin
        // Move-to-front: only entries below the match shift down.
        for (int i = 1; i < DEPTH; i++) begin
          if (i <= int'(match_idx)) entries_d[i] = entries_q[i-1];
        end
        entries_d[0] = data_in;
      end
    end

    // Comparing next against current covers the corner cases (clear of an
    // empty history, clear rewriting the same single entry) uniformly.
    upd_d     = (entries_d != entries_q) || (valid_d != valid_q);
    upd_cnt_d = upd_cnt_q;
    if (upd_d && (upd_cnt_q != UPD_MAX)) upd_cnt_d = upd_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= ST_IDLE;
      entries_q <= '0;
      valid_q   <= '0;
      count_q   <= '0;
      hit_q     <= 1'b0;
      idx_q     <= '0;
      upd_q     <= 1'b0;
      upd_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      entries_q <= entries_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      hit_q     <= hit_d;
      idx_q     <= idx_d;
      upd_q     <= upd_d;
      upd_cnt_q <= upd_cnt_d;
    end
  end

  assign hist_data   = entries_q;
  assign hist_valid  = valid_q;
  assign count_out   = count_q;
  assign hit_out     = hit_q;
  assign hit_idx     = idx_q;
  assign update_out  = upd_q;
  assign upd_cnt_out = upd_cnt_q;

endmodule
